// File: rtl/sevenseg_pkg.sv
// Shared seven-segment encode/decode tables.
// Used by both the display driver and the bus decoder.
package sevenseg_pkg;

    typedef logic [3:0] digit_t;
    typedef logic [6:0] seg_t;

    localparam seg_t SEG_0     = 7'h3F;
    localparam seg_t SEG_1     = 7'h06;
    localparam seg_t SEG_2     = 7'h5B;
    localparam seg_t SEG_3     = 7'h4F;
    localparam seg_t SEG_4     = 7'h66;
    localparam seg_t SEG_5     = 7'h6D;
    localparam seg_t SEG_6     = 7'h7D;
    localparam seg_t SEG_7     = 7'h07;
    localparam seg_t SEG_8     = 7'h7F;
    localparam seg_t SEG_9     = 7'h6F;
    localparam seg_t SEG_BLANK = 7'h00;

    localparam digit_t DIGIT_BLANK = 4'hF;
    localparam digit_t DIGIT_ERR   = 4'hE;

    function automatic digit_t seg_to_digit(input seg_t seg);
        digit_t d;
        case (seg)
            SEG_0:     d = 4'd0;
            SEG_1:     d = 4'd1;
            SEG_2:     d = 4'd2;
            SEG_3:     d = 4'd3;
            SEG_4:     d = 4'd4;
            SEG_5:     d = 4'd5;
            SEG_6:     d = 4'd6;
            SEG_7:     d = 4'd7;
            SEG_8:     d = 4'd8;
            SEG_9:     d = 4'd9;
            SEG_BLANK: d = DIGIT_BLANK;
            default:   d = DIGIT_ERR;
        endcase
        return d;
    endfunction

endpackage

// File: rtl/sevenseg_mux_decoder_if.sv
// Display bus in, recovered digits and event pulses out.
// slave = decoder side, master = bus source / observer.
interface sevenseg_mux_decoder_if;
    logic [7:0] seg_in;
    logic [3:0] tens_o;
    logic [3:0] ones_o;
    logic       frame_valid;
    logic       changed;
    logic       seg_err;

    modport slave (
        input  seg_in,
        output tens_o, ones_o, frame_valid, changed, seg_err
    );

    modport master (
        output seg_in,
        input  tens_o, ones_o, frame_valid, changed, seg_err
    );
endinterface

// File: rtl/sevenseg_mux_decoder_phase_capture.sv
// Samples the display bus and emits one capture per stable phase.
// Capture data refers to s_prev, whose run length run_len tracks.
module sevenseg_phase_capture #(
    parameter int STABLE_CYCLES = 2,
    parameter int CNT_W         = 4
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [7:0] seg_in,
    output logic       cap_pulse,
    output logic       cap_sel,
    output logic [6:0] cap_seg,
    output logic       phase_miss
);
    localparam logic [CNT_W-1:0] RUN_MAX = CNT_W'(STABLE_CYCLES);

    logic [7:0]       s_q, s_d;
    logic [7:0]       s_prev_q, s_prev_d;
    logic [CNT_W-1:0] run_len_q, run_len_d;
    logic             captured_q, captured_d;
    logic             sel_flip;

    // Run-length tracking, phase boundary and capture decision.
    always_comb begin
        s_d        = seg_in;
        s_prev_d   = s_q;
        sel_flip   = s_q[7] ^ s_prev_q[7];
        cap_pulse  = (run_len_q == RUN_MAX) && !captured_q;
        phase_miss = sel_flip && !captured_q && !cap_pulse;
        cap_sel    = s_prev_q[7];
        cap_seg    = s_prev_q[6:0];
        if (s_q != s_prev_q)
            run_len_d = CNT_W'(1);
        else if (run_len_q < RUN_MAX)
            run_len_d = run_len_q + CNT_W'(1);
        else
            run_len_d = RUN_MAX;
        if (sel_flip)
            captured_d = 1'b0;
        else if (cap_pulse)
            captured_d = 1'b1;
        else
            captured_d = captured_q;
    end

    // Sampling and run-state registers.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            s_q        <= 8'h00;
            s_prev_q   <= 8'h00;
            run_len_q  <= '0;
            captured_q <= 1'b0;
        end else begin
            s_q        <= s_d;
            s_prev_q   <= s_prev_d;
            run_len_q  <= run_len_d;
            captured_q <= captured_d;
        end
    end

endmodule

// File: rtl/sevenseg_mux_decoder.sv
// Recovers tens/ones digits from the multiplexed display bus.
// Pairs a tens capture with the following ones capture into a frame.
module sevenseg_mux_decoder
    import sevenseg_pkg::*;
#(
    parameter int STABLE_CYCLES = 2,
    parameter int CNT_W         = 4
) (
    input logic                  clk,
    input logic                  reset,
    sevenseg_mux_decoder_if.slave bus
);
    logic       cap_pulse;
    logic       cap_sel;
    logic [6:0] cap_seg;
    logic       phase_miss;
    digit_t     code;

    digit_t tens_q, tens_d;
    digit_t ones_q, ones_d;
    digit_t shadow_q, shadow_d;
    logic   pending_q, pending_d;
    logic   frame_q, frame_d;
    logic   changed_q, changed_d;
    logic   err_q, err_d;

    sevenseg_phase_capture #(
        .STABLE_CYCLES (STABLE_CYCLES),
        .CNT_W         (CNT_W)
    ) u_cap (
        .clk        (clk),
        .reset      (reset),
        .seg_in     (bus.seg_in),
        .cap_pulse  (cap_pulse),
        .cap_sel    (cap_sel),
        .cap_seg    (cap_seg),
        .phase_miss (phase_miss)
    );

    // Frame sequencer: hold tens, publish on the matching ones.
    always_comb begin
        code      = seg_to_digit(cap_seg);
        tens_d    = tens_q;
        ones_d    = ones_q;
        shadow_d  = shadow_q;
        pending_d = pending_q;
        frame_d   = 1'b0;
        changed_d = 1'b0;
        err_d     = 1'b0;
        if (cap_pulse) begin
            err_d = (code == DIGIT_ERR);
            if (cap_sel) begin
                shadow_d  = code;
                pending_d = 1'b1;
            end else if (pending_q) begin
                tens_d    = shadow_q;
                ones_d    = code;
                frame_d   = 1'b1;
                changed_d = (shadow_q != tens_q) || (code != ones_q);
                pending_d = 1'b0;
            end
        end else if (phase_miss) begin
            pending_d = 1'b0;
        end
    end

    // Registered outputs and sequencer state.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            tens_q    <= DIGIT_BLANK;
            ones_q    <= DIGIT_BLANK;
            shadow_q  <= DIGIT_BLANK;
            pending_q <= 1'b0;
            frame_q   <= 1'b0;
            changed_q <= 1'b0;
            err_q     <= 1'b0;
        end else begin
            tens_q    <= tens_d;
            ones_q    <= ones_d;
            shadow_q  <= shadow_d;
            pending_q <= pending_d;
            frame_q   <= frame_d;
            changed_q <= changed_d;
            err_q     <= err_d;
        end
    end

    assign bus.tens_o      = tens_q;
    assign bus.ones_o      = ones_q;
    assign bus.frame_valid = frame_q;
    assign bus.changed     = changed_q;
    assign bus.seg_err     = err_q;

endmodule
